instruction_fetch_unit: RTL and testbench

Front-end fetch stage of the RV32IM pipeline. Holds the program counter, runs the request/busywait handshake with instruction memory, and presents a registered 32-bit `INSTRUCTION` (plus its `PC`) to the control unit and decode stage. Supports pipeline stalls through a one-entry skid buffer, and branch/jump redirects with discard of in-flight fetches.

---
 rtl/instruction_fetch_unit.sv | 208 ++++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front-end fetch stage of the RV32IM pipeline. This block holds the program
// counter and drives the request/busywait handshake with instruction memory.
// It presents a registered instruction and its address to decode. It also
// absorbs one in-flight fetch into a skid buffer while decode is stalled, and
// it discards fetches that are still in flight when a branch/jump redirects
// the stream.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a target that is not word aligned raises the
//               sticky fetch_fault flag and halts fetching until RESET.
//   undefined : branch_target[1:0] is ignored (forced to 2'b00), and
//               fetch_fault is tied to 0.
//
// Ports
//   CLK            in   1   clock, rising edge
//   RESET          in   1   asynchronous active-high reset
//   stall          in   1   decode/hazard stall, output registers hold
//   branch_taken   in   1   redirect request from execute
//   branch_target  in  32   redirect address
//   imem_read      out  1   instruction memory read request
//   imem_address   out 32   instruction memory address (= next fetch PC)
//   imem_readdata  in  32   instruction memory read data
//   imem_busywait  in   1   memory not ready
//   INSTRUCTION    out 32   fetched instruction (NOP_INSTR when invalid)
//   PC             out 32   address of INSTRUCTION
//   PC_PLUS_4      out 32   PC + 4 (link value)
//   instr_valid    out  1   INSTRUCTION/PC hold a real instruction
//   fetch_fault    out  1   misaligned redirect trap (optional feature)
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_readdata,
  input  logic        imem_busywait,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS_4,
  output logic        instr_valid,
  output logic        fetch_fault
);

  // FETCH: requesting at r_pc. DRAIN: waiting out a request made before a
  // redirect. HOLD: skid buffer full while stalled. HALT: misaligned-redirect
  // trap (reachable only with FETCH_MISALIGN_TRAP_EN).
  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_DRAIN = 2'b01,
    S_HOLD  = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;          // next fetch address
  logic        r_skid_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic        r_instr_valid;

  logic        w_req_state;
  logic        w_complete;
  logic        w_outstanding;
  logic [31:0] w_pc_inc;
  logic [31:0] w_target;
  logic        w_misalign;

  // The request is decoded from the registered state. It is also gated by
  // RESET, so an asserted reset drops it at once instead of at the next edge.
  assign w_req_state   = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign imem_read     = w_req_state & ~RESET;
  assign imem_address  = r_pc;
  assign w_complete    = imem_read & ~imem_busywait;
  assign w_outstanding = imem_read &  imem_busywait;
  // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0.
  assign w_pc_inc      = r_pc + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_target   = branch_target;
  assign w_misalign = (branch_target[1:0] != 2'b00);
`else
  assign w_target   = branch_target & 32'hFFFF_FFFC;
  assign w_misalign = 1'b0;
`endif

  assign INSTRUCTION = r_instr;
  assign PC          = r_pc_out;
  assign PC_PLUS_4   = r_pc_out + 32'd4;
  assign instr_valid = r_instr_valid;

  // Fetch sequencer: state, PC, skid buffer and registered decode outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_skid_valid  <= 1'b0;
      r_skid_instr  <= NOP_INSTR;
      r_skid_pc     <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_pc_out      <= RESET_PC;
      r_instr_valid <= 1'b0;
    end else if (r_state == S_HALT) begin
      // Trapped: nothing valid is presented and nothing is fetched until reset.
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
      r_skid_valid  <= 1'b0;
    end else if (branch_taken) begin
      // Redirect wins over stall and over a completing fetch. Any data that
      // arrives in this cycle belongs to the old stream and is dropped.
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
      r_skid_valid  <= 1'b0;
      if (w_misalign) begin
        r_state <= S_HALT;
      end else begin
        r_pc <= w_target;
        // A request still pending must be drained before the target is
        // requested, or its late data would look like the target's.
        if (w_outstanding) begin
          r_state <= S_DRAIN;
        end else begin
          r_state <= S_FETCH;
        end
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_complete) begin
            r_pc <= w_pc_inc;
            if (stall) begin
              // Decode cannot take it, so park the word. Requests stop while
              // the buffer is full.
              r_skid_instr <= imem_readdata;
              r_skid_pc    <= r_pc;
              r_skid_valid <= 1'b1;
              r_state      <= S_HOLD;
            end else begin
              r_instr       <= imem_readdata;
              r_pc_out      <= r_pc;
              r_instr_valid <= 1'b1;
              r_state       <= S_FETCH;
            end
          end else if (!stall) begin
            // Memory still busy: insert a bubble.
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_DRAIN: begin
          // Outputs already show a bubble from the redirect. Only the
          // completion of the stale request matters here.
          if (w_complete) begin
            r_state <= S_FETCH;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_instr       <= r_skid_instr;
            r_pc_out      <= r_skid_pc;
            r_instr_valid <= r_skid_valid;
            r_skid_valid  <= 1'b0;
            r_state       <= S_FETCH;
          end else begin
            r_state <= S_HOLD;
          end
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_fault;

  // Sticky misaligned-redirect flag. Only reset clears it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_fault <= 1'b0;
    end else if ((r_state != S_HALT) && branch_taken && w_misalign) begin
      r_fault <= 1'b1;
    end else begin
      r_fault <= r_fault;
    end
  end

  assign fetch_fault = r_fault;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit. The memory model returns
// word k = 32'h13 + (k << 7) at address 4k, after wait_n busywait cycles per
// request. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        CLK;
  logic        RESET;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_readdata;
  logic        imem_busywait;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC;
  logic [31:0] PC_PLUS_4;
  logic        instr_valid;
  logic        fetch_fault;

  int errors;
  int checks;
  int wait_n;
  int busy_cnt;
  int completions;
  int c0;

  instruction_fetch_unit dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_read     (imem_read),
    .imem_address  (imem_address),
    .imem_readdata (imem_readdata),
    .imem_busywait (imem_busywait),
    .INSTRUCTION   (INSTRUCTION),
    .PC            (PC),
    .PC_PLUS_4     (PC_PLUS_4),
    .instr_valid   (instr_valid),
    .fetch_fault   (fetch_fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0013 + ((a >> 2) << 7);
  endfunction

  assign imem_readdata = mem_word(imem_address);
  assign imem_busywait = imem_read && (busy_cnt < wait_n);

  // Memory wait counter and completed-transaction counter.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      busy_cnt <= 0;
    end else if (imem_read && !imem_busywait) begin
      busy_cnt    <= 0;
      completions <= completions + 1;
    end else if (imem_read) begin
      busy_cnt <= busy_cnt + 1;
    end else begin
      busy_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Watchdog: the directed sequence is short. This only guards against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    errors        = 0;
    checks        = 0;
    completions   = 0;
    wait_n        = 0;
    RESET         = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0000_0000;

    // ---- reset state ----
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_read",  {31'd0, imem_read},   32'd0);
    chk("rst_addr",  imem_address,         32'h0000_0000);
    chk("rst_instr", INSTRUCTION,          32'h0000_0013);
    chk("rst_pc",    PC,                   32'h0000_0000);
    chk("rst_pc4",   PC_PLUS_4,            32'h0000_0004);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);

    // ---- zero-wait streaming ----
    RESET = 1'b0;
    #1;
    chk("c1_read", {31'd0, imem_read}, 32'd1);
    chk("c1_addr", imem_address,       32'h0000_0000);
    step();
    chk("s0_pc",    PC,                   32'h0000_0000);
    chk("s0_instr", INSTRUCTION,          32'h0000_0013);
    chk("s0_valid", {31'd0, instr_valid}, 32'd1);
    chk("s0_pc4",   PC_PLUS_4,            32'h0000_0004);
    step();
    chk("s1_pc",    PC,           32'h0000_0004);
    chk("s1_instr", INSTRUCTION,  32'h0000_0093);
    chk("s1_addr",  imem_address, 32'h0000_0008);
    step();
    chk("s2_pc",    PC,                   32'h0000_0008);
    chk("s2_instr", INSTRUCTION,          32'h0000_0113);
    chk("s2_valid", {31'd0, instr_valid}, 32'd1);

    // ---- stall for 3 cycles at PC=8; the fetch of 12 goes to the skid ----
    c0    = completions;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_pc",    PC,                   32'h0000_0008);
      chk("stl_instr", INSTRUCTION,          32'h0000_0113);
      chk("stl_valid", {31'd0, instr_valid}, 32'd1);
      chk("stl_read",  {31'd0, imem_read},   32'd0);
    end
    chk("stl_one_fetch", completions - c0, 32'd1);
    stall = 1'b0;
    step();
    chk("rel_pc",    PC,                   32'h0000_000C);
    chk("rel_instr", INSTRUCTION,          32'h0000_0193);
    chk("rel_valid", {31'd0, instr_valid}, 32'd1);
    step();
    chk("rel2_pc",    PC,          32'h0000_0010);
    chk("rel2_instr", INSTRUCTION, 32'h0000_0213);

    // ---- two wait cycles per access: 2 bubbles between instructions ----
    wait_n = 2;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bw_bub_valid", {31'd0, instr_valid}, 32'd0);
      chk("bw_bub_instr", INSTRUCTION,          32'h0000_0013);
      chk("bw_bub_addr",  imem_address,         32'h0000_0014);
    end
    step();
    chk("bw_pc20",    PC,                   32'h0000_0014);
    chk("bw_instr20", INSTRUCTION,          32'h0000_0293);
    chk("bw_valid20", {31'd0, instr_valid}, 32'd1);
    step();
    chk("bw_bub2", {31'd0, instr_valid}, 32'd0);
    step();
    chk("bw_bub3", {31'd0, instr_valid}, 32'd0);
    step();
    chk("bw_pc24",    PC,          32'h0000_0018);
    chk("bw_instr24", INSTRUCTION, 32'h0000_0313);

    // ---- redirect to 0x100 while the fetch of 28 is busy: drain ----
    chk("br_busy", {31'd0, imem_busywait}, 32'd1);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0100;
    step();
    branch_taken = 1'b0;
    chk("dr_valid0", {31'd0, instr_valid}, 32'd0);
    chk("dr_instr0", INSTRUCTION,          32'h0000_0013);
    chk("dr_addr",   imem_address,         32'h0000_0100);
    chk("dr_read",   {31'd0, imem_read},   32'd1);
    step();
    chk("dr_valid1", {31'd0, instr_valid}, 32'd0);
    step();
    // The stale fetch of 28 completes here and must be discarded.
    chk("dr_valid2", {31'd0, instr_valid}, 32'd0);
    chk("dr_instr2", INSTRUCTION,          32'h0000_0013);
    wait_n = 0;
    step();
    chk("br_pc",    PC,                   32'h0000_0100);
    chk("br_instr", INSTRUCTION,          32'h0000_2013);
    chk("br_valid", {31'd0, instr_valid}, 32'd1);

    // ---- redirect to the top of memory: the PC wraps ----
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    chk("wr_bub",  {31'd0, instr_valid}, 32'd0);
    chk("wr_addr", imem_address,         32'hFFFF_FFFC);
    step();
    chk("wr_pc",    PC,           32'hFFFF_FFFC);
    chk("wr_instr", INSTRUCTION,  32'hFFFF_FF93);
    chk("wr_pc4",   PC_PLUS_4,    32'h0000_0000);
    chk("wr_addr0", imem_address, 32'h0000_0000);
    step();
    chk("wr_pc0",    PC,                   32'h0000_0000);
    chk("wr_instr0", INSTRUCTION,          32'h0000_0013);
    chk("wr_valid0", {31'd0, instr_valid}, 32'd1);
    step();
    chk("wr_pc4b", PC, 32'h0000_0004);

    // ---- misaligned redirect to 0x102 ----
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0102;
    step();
    branch_taken = 1'b0;
    chk("ma_bub", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("ma_fault", {31'd0, fetch_fault}, 32'd1);
    chk("ma_read",  {31'd0, imem_read},   32'd0);
    step();
    chk("ma_fault2", {31'd0, fetch_fault}, 32'd1);
    chk("ma_read2",  {31'd0, imem_read},   32'd0);
    chk("ma_valid2", {31'd0, instr_valid}, 32'd0);
`else
    chk("ma_fault", {31'd0, fetch_fault}, 32'd0);
    chk("ma_addr",  imem_address,         32'h0000_0100);
    step();
    chk("ma_pc",    PC,                   32'h0000_0100);
    chk("ma_instr", INSTRUCTION,          32'h0000_2013);
    chk("ma_valid", {31'd0, instr_valid}, 32'd1);
`endif

    // ---- reset asserted mid-transaction drops the request at once ----
    wait_n = 3;
    step();
    RESET = 1'b1;
    #1;
    chk("mr_read",  {31'd0, imem_read},   32'd0);
    chk("mr_valid", {31'd0, instr_valid}, 32'd0);
    chk("mr_instr", INSTRUCTION,          32'h0000_0013);
    chk("mr_pc",    PC,                   32'h0000_0000);
    chk("mr_addr",  imem_address,         32'h0000_0000);
    chk("mr_fault", {31'd0, fetch_fault}, 32'd0);
    wait_n = 0;
    step();
    RESET = 1'b0;
    step();
    chk("mr_restart_pc",    PC,                   32'h0000_0000);
    chk("mr_restart_valid", {31'd0, instr_valid}, 32'd1);
    step();
    chk("mr_restart_pc4", PC, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
